iob_wb_master_bridge: RTL and testbench

- Converts the iob native request bus (valid/address/wdata/wstrb -> rdata/ready) into single Wishbone classic master cycles.
- Sits directly upstream of the ethmac Wishbone register slave inside the ethernet subsystem; the CPU or bench drives it.
- Accepts one-cycle valid pulses, holds the request until the slave acks, errs or times out, and returns a one-cycle ready pulse.
- Keeps sticky error/timeout status for software.

---
 rtl/iob_wb_master_bridge.sv | 129 ++++++++++++
 tb/tb_iob_wb_master_bridge.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/iob_wb_master_bridge.sv
// rtl/iob_wb_master_bridge.sv - iob native request bus to single Wishbone classic master cycles
module iob_wb_master_bridge #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT_W = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic                clk_i,
    input  logic                arst_i,
    input  logic                valid,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   rdata,
    output logic                ready,
    output logic                busy_o,
    output logic                err_o,
    output logic                tout_o,
    input  logic                stat_clr_i,
    output logic [ADDR_W-1:0]   wb_adr_o,
    output logic [DATA_W-1:0]   wb_dat_o,
    output logic [DATA_W/8-1:0] wb_sel_o,
    output logic                wb_we_o,
    output logic                wb_cyc_o,
    output logic                wb_stb_o,
    input  logic [DATA_W-1:0]   wb_dat_i,
    input  logic                wb_ack_i,
    input  logic                wb_err_i
);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

    localparam int                   TO_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [TIMEOUT_W-1:0] TO_LAST   = TO_LAST_I[TIMEOUT_W-1:0];

    state_t                r_state;
    logic [TIMEOUT_W-1:0]  r_cnt;
    logic [DATA_W-1:0]     r_rdata;
    logic                  r_ready;
    logic                  r_busy;
    logic                  r_err;
    logic                  r_tout;
    logic [ADDR_W-1:0]     r_adr;
    logic [DATA_W-1:0]     r_dat;
    logic [DATA_W/8-1:0]   r_sel;
    logic                  r_we;
    logic                  r_cyc;

    logic                  w_tout_hit;
    logic                  w_done;

    assign w_tout_hit = (TIMEOUT != 0) && (r_cnt == TO_LAST);
    assign w_done     = wb_ack_i || wb_err_i || w_tout_hit;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
            r_tout  <= 1'b0;
            r_adr   <= '0;
            r_dat   <= '0;
            r_sel   <= '0;
            r_we    <= 1'b0;
            r_cyc   <= 1'b0;
        end else begin
            // Clear first so a status event in the same cycle overrides it
            if (stat_clr_i) begin
                r_err  <= 1'b0;
                r_tout <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (valid) begin
                        r_adr   <= address;
                        r_dat   <= wdata;
                        r_we    <= |wstrb;
                        r_sel   <= (|wstrb) ? wstrb : '1;
                        r_cyc   <= 1'b1;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_BUS;
                    end
                end
                S_BUS: begin
                    if (w_done) begin
                        r_cyc   <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= S_RESP;
                    end
                    // Ack outranks err, both outrank the timeout
                    if (wb_ack_i) begin
                        r_rdata <= r_we ? '0 : wb_dat_i;
                    end else if (wb_err_i) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                    end else if (w_tout_hit) begin
                        r_rdata <= '0;
                        r_tout  <= 1'b1;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rdata    = r_rdata;
    assign ready    = r_ready;
    assign busy_o   = r_busy;
    assign err_o    = r_err;
    assign tout_o   = r_tout;
    assign wb_adr_o = r_adr;
    assign wb_dat_o = r_dat;
    assign wb_sel_o = r_sel;
    assign wb_we_o  = r_we;
    assign wb_cyc_o = r_cyc;
    assign wb_stb_o = r_cyc;

endmodule

// File: tb/tb_iob_wb_master_bridge.sv
// tb/tb_iob_wb_master_bridge.sv - randomized self-checking bench for iob_wb_master_bridge
module tb_iob_wb_master_bridge;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 16;

    logic          clk_i = 1'b0;
    logic          arst_i = 1'b1;
    logic          valid = 1'b0;
    logic [AW-1:0] address = '0;
    logic [DW-1:0] wdata = '0;
    logic [SW-1:0] wstrb = '0;
    logic [DW-1:0] rdata;
    logic          ready;
    logic          busy_o;
    logic          err_o;
    logic          tout_o;
    logic          stat_clr_i = 1'b0;
    logic [AW-1:0] wb_adr_o;
    logic [DW-1:0] wb_dat_o;
    logic [SW-1:0] wb_sel_o;
    logic          wb_we_o;
    logic          wb_cyc_o;
    logic          wb_stb_o;
    logic [DW-1:0] wb_dat_i = '0;
    logic          wb_ack_i = 1'b0;
    logic          wb_err_i = 1'b0;

    iob_wb_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_W(8), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .arst_i(arst_i), .valid(valid), .address(address), .wdata(wdata),
        .wstrb(wstrb), .rdata(rdata), .ready(ready), .busy_o(busy_o), .err_o(err_o),
        .tout_o(tout_o), .stat_clr_i(stat_clr_i), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
        .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    int            o_stb, o_rdy, o_lat, o_busy_k;
    bit            o_hung, o_stable;
    logic [DW-1:0] o_rd, o_dat;
    logic [AW-1:0] o_adr;
    logic [SW-1:0] o_sel;
    logic          o_we;

    // mode: 0 ack, 1 err, 2 silent slave, 3 ack+err together; response in stb cycle waits+1
    task automatic do_txn(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                          input int mode, input int waits, input logic [DW-1:0] sd, input bit clr);
        int target;
        target = (mode == 2 || waits + 1 > TO) ? TO : waits + 1;
        o_stb = 0; o_rdy = 0; o_lat = -1; o_busy_k = -1; o_hung = 1; o_stable = 1; o_rd = '0;
        @(negedge clk_i);
        valid = 1'b1; address = a; wdata = d; wstrb = s;
        @(negedge clk_i);
        valid = 1'b0; address = AW'($urandom); wdata = $urandom; wstrb = SW'($urandom);
        for (int k = 0; k < 200; k++) begin
            if (wb_cyc_o !== wb_stb_o) o_stable = 0;
            if (wb_cyc_o && wb_stb_o) begin
                if (o_stb == 0) begin
                    o_adr = wb_adr_o; o_dat = wb_dat_o; o_sel = wb_sel_o; o_we = wb_we_o;
                end else if (o_adr !== wb_adr_o || o_dat !== wb_dat_o || o_sel !== wb_sel_o || o_we !== wb_we_o) begin
                    o_stable = 0;
                end
                o_stb++;
            end
            if (ready) begin o_rdy++; o_rd = rdata; o_lat = k; end
            if (!busy_o) begin o_busy_k = k; o_hung = 0; break; end
            wb_ack_i   = wb_cyc_o && mode != 2 && o_stb == waits + 1 && (mode == 0 || mode == 3);
            wb_err_i   = wb_cyc_o && mode != 2 && o_stb == waits + 1 && (mode == 1 || mode == 3);
            wb_dat_i   = (o_stb == waits + 1) ? sd : $urandom;
            stat_clr_i = clr && wb_cyc_o && o_stb == target;
            @(negedge clk_i);
        end
        wb_ack_i = 1'b0; wb_err_i = 1'b0; stat_clr_i = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk_i); stat_clr_i = 1'b1;
        @(negedge clk_i); stat_clr_i = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk_i);
        n_tests++; if ({rdata, ready, busy_o, err_o, tout_o} !== '0) begin n_fail++; $display("FAIL reset_status: got %h expected 0", {rdata, ready, busy_o, err_o, tout_o}); end
        n_tests++; if ({wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o} !== '0) begin n_fail++; $display("FAIL reset_wb: got %h expected 0", {wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o}); end
        arst_i = 1'b0;
    endtask

    task automatic test_write();
        do_txn(12'h000, 32'h0000A080, 4'hF, 0, 0, 32'h0, 1'b0);
        n_tests++; if (o_we !== 1'b1 || o_sel !== 4'hF || o_dat !== 32'h0000A080 || o_adr !== 12'h000) begin n_fail++; $display("FAIL write_wb: got we=%b sel=%h dat=%h adr=%h expected 1 f 0000a080 000", o_we, o_sel, o_dat, o_adr); end
        n_tests++; if (o_stb != 1) begin n_fail++; $display("FAIL write_stb_cycles: got %0d expected 1", o_stb); end
        n_tests++; if (o_rdy != 1 || o_lat != 1) begin n_fail++; $display("FAIL write_ready: got count=%0d at=%0d expected 1 at 1", o_rdy, o_lat); end
        n_tests++; if (o_busy_k != 2) begin n_fail++; $display("FAIL write_busy_drop: got %0d expected 2", o_busy_k); end
    endtask

    task automatic test_read_wait();
        do_txn(12'h000, 32'h12345678, 4'h0, 0, 4, 32'h0000A480, 1'b0);
        n_tests++; if (o_we !== 1'b0 || o_sel !== 4'hF) begin n_fail++; $display("FAIL read_wb: got we=%b sel=%h expected 0 f", o_we, o_sel); end
        n_tests++; if (o_stb != 5) begin n_fail++; $display("FAIL read_stb_cycles: got %0d expected 5", o_stb); end
        n_tests++; if (o_rdy != 1 || o_rd !== 32'h0000A480) begin n_fail++; $display("FAIL read_data: got count=%0d rdata=%h expected 1 0000a480", o_rdy, o_rd); end
        @(negedge clk_i);
        n_tests++; if (rdata !== 32'h0000A480) begin n_fail++; $display("FAIL read_hold: got %h expected 0000a480", rdata); end
    endtask

    task automatic test_error();
        do_txn(12'h005, $urandom, 4'h3, 1, 2, $urandom, 1'b0);
        n_tests++; if (o_sel !== 4'h3 || o_we !== 1'b1) begin n_fail++; $display("FAIL err_wb: got sel=%h we=%b expected 3 1", o_sel, o_we); end
        n_tests++; if (o_rdy != 1 || o_rd !== '0 || err_o !== 1'b1) begin n_fail++; $display("FAIL err_resp: got count=%0d rdata=%h err=%b expected 1 0 1", o_rdy, o_rd, err_o); end
        do_txn(12'h006, $urandom, 4'h0, 0, 1, 32'hCAFE0001, 1'b0);
        n_tests++; if (err_o !== 1'b1 || o_rd !== 32'hCAFE0001) begin n_fail++; $display("FAIL err_sticky: got err=%b rdata=%h expected 1 cafe0001", err_o, o_rd); end
        pulse_clr();
        n_tests++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b expected 0", err_o); end
        do_txn(12'h007, $urandom, 4'hF, 1, 0, $urandom, 1'b1);
        n_tests++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL err_set_wins: got %b expected 1", err_o); end
        pulse_clr();
    endtask

    task automatic test_timeout();
        do_txn(12'h0A5, $urandom, 4'h0, 2, 0, $urandom, 1'b0);
        n_tests++; if (o_stb != TO || o_lat != TO) begin n_fail++; $display("FAIL tout_cycles: got stb=%0d ready_at=%0d expected %0d", o_stb, o_lat, TO); end
        n_tests++; if (o_rdy != 1 || tout_o !== 1'b1 || err_o !== 1'b0 || o_rd !== '0) begin n_fail++; $display("FAIL tout_flags: got count=%0d tout=%b err=%b rdata=%h expected 1 1 0 0", o_rdy, tout_o, err_o, o_rd); end
        do_txn(12'h0A6, $urandom, 4'h0, 0, 1, 32'h5A5A0F0F, 1'b0);
        n_tests++; if (o_stb != 2 || o_rdy != 1 || o_rd !== 32'h5A5A0F0F || tout_o !== 1'b1) begin n_fail++; $display("FAIL tout_after: got stb=%0d count=%0d rdata=%h tout=%b expected 2 1 5a5a0f0f 1", o_stb, o_rdy, o_rd, tout_o); end
        pulse_clr();
        n_tests++; if (tout_o !== 1'b0) begin n_fail++; $display("FAIL tout_clear: got %b expected 0", tout_o); end
    endtask

    task automatic test_back_to_back();
        int extra;
        @(negedge clk_i); valid = 1'b1; address = 12'h111; wstrb = 4'h0;
        @(negedge clk_i);
        n_tests++; if (wb_cyc_o !== 1'b1 || wb_adr_o !== 12'h111) begin n_fail++; $display("FAIL b2b_issue: got cyc=%b adr=%h expected 1 111", wb_cyc_o, wb_adr_o); end
        address = 12'h222;
        @(negedge clk_i);
        n_tests++; if (wb_cyc_o !== 1'b1 || wb_adr_o !== 12'h111) begin n_fail++; $display("FAIL b2b_hold: got cyc=%b adr=%h expected 1 111", wb_cyc_o, wb_adr_o); end
        address = 12'h333; wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_dat_i = 32'hBEEF0333;
        @(negedge clk_i);
        wb_ack_i = 1'b0; wb_err_i = 1'b0;
        n_tests++; if (ready !== 1'b1 || rdata !== 32'hBEEF0333 || err_o !== 1'b0) begin n_fail++; $display("FAIL b2b_ackerr: got ready=%b rdata=%h err=%b expected 1 beef0333 0", ready, rdata, err_o); end
        @(negedge clk_i);
        valid = 1'b0;
        extra = 0;
        for (int k = 0; k < 6; k++) begin
            if (wb_cyc_o || busy_o) extra++;
            @(negedge clk_i);
        end
        n_tests++; if (extra != 0) begin n_fail++; $display("FAIL b2b_dropped: got %0d busy cycles expected 0", extra); end
    endtask

    task automatic test_reset_mid();
        int bad;
        @(negedge clk_i); valid = 1'b1; address = 12'h009; wstrb = 4'hF; wdata = $urandom;
        @(negedge clk_i); valid = 1'b0;
        repeat (3) @(negedge clk_i);
        arst_i = 1'b1;
        #1;
        n_tests++; if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || busy_o !== 1'b0 || ready !== 1'b0) begin n_fail++; $display("FAIL rst_async: got cyc=%b stb=%b busy=%b ready=%b expected 0", wb_cyc_o, wb_stb_o, busy_o, ready); end
        bad = 0;
        for (int k = 0; k < 3; k++) begin @(negedge clk_i); if (ready) bad++; end
        arst_i = 1'b0;
        for (int k = 0; k < 3; k++) begin @(negedge clk_i); if (ready || wb_cyc_o) bad++; end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL rst_no_ready: got %0d stray cycles expected 0", bad); end
        do_txn(12'h001, 32'h01020304, 4'hF, 0, 1, $urandom, 1'b0);
        n_tests++; if (o_rdy != 1 || o_adr !== 12'h001 || o_we !== 1'b1 || o_stb != 2 || o_rd !== '0) begin n_fail++; $display("FAIL rst_recover: got count=%0d adr=%h we=%b stb=%0d rdata=%h expected 1 001 1 2 0", o_rdy, o_adr, o_we, o_stb, o_rd); end
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        logic [DW-1:0] d, sd, e_rd;
        logic [SW-1:0] s;
        int mode, waits, e_stb;
        bit clr, responded, e_we, e_ack, e_err_ev, e_tout_ev;
        logic e_err, e_tout;
        e_err = err_o; e_tout = tout_o;
        for (int i = 0; i < 24; i++) begin
            a = AW'($urandom); d = $urandom; sd = $urandom;
            s = ($urandom_range(0, 2) == 0) ? 4'h0 : SW'($urandom_range(1, 15));
            mode = $urandom_range(0, 3); waits = $urandom_range(0, 19);
            clr = ($urandom_range(0, 3) == 0);
            e_we      = (s != 0);
            responded = (mode != 2) && (waits + 1 <= TO);
            e_stb     = responded ? waits + 1 : TO;
            e_ack     = responded && (mode == 0 || mode == 3);
            e_err_ev  = responded && mode == 1;
            e_tout_ev = !responded;
            e_rd      = (e_ack && !e_we) ? sd : '0;
            e_err     = (clr ? 1'b0 : e_err) | e_err_ev;
            e_tout    = (clr ? 1'b0 : e_tout) | e_tout_ev;
            do_txn(a, d, s, mode, waits, sd, clr);
            n_tests++; if (o_hung || o_rdy != 1 || o_lat != e_stb || o_busy_k != e_stb + 1) begin n_fail++; $display("FAIL rnd%0d_timing: got hung=%0d count=%0d ready_at=%0d idle_at=%0d expected 0 1 %0d %0d", i, o_hung, o_rdy, o_lat, o_busy_k, e_stb, e_stb + 1); end
            n_tests++; if (o_stb != e_stb || !o_stable) begin n_fail++; $display("FAIL rnd%0d_stb: got cycles=%0d stable=%0d expected %0d 1", i, o_stb, o_stable, e_stb); end
            n_tests++; if (o_adr !== a || o_dat !== d || o_we !== e_we || o_sel !== (e_we ? s : 4'hF)) begin n_fail++; $display("FAIL rnd%0d_req: got adr=%h dat=%h we=%b sel=%h expected %h %h %b %h", i, o_adr, o_dat, o_we, o_sel, a, d, e_we, e_we ? s : 4'hF); end
            n_tests++; if (o_rd !== e_rd) begin n_fail++; $display("FAIL rnd%0d_rdata: got %h expected %h", i, o_rd, e_rd); end
            n_tests++; if (err_o !== e_err || tout_o !== e_tout) begin n_fail++; $display("FAIL rnd%0d_flags: got err=%b tout=%b expected %b %b", i, err_o, tout_o, e_err, e_tout); end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_error();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
